// File: rtl/io_responder.sv
// I/O-window responder for the CPU byte bus: UART TX/RX FIFOs, cycle counter with
// read snapshot, and a RUN/DRAIN/DONE finish sequence that flushes TX before signalling exit.
module io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_AW          = 4,
    parameter int RX_AW          = 4,
    parameter int FULL_MARGIN    = 2
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  io_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        program_finish,
    output logic [7:0]  exit_code
);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    localparam logic [TX_AW:0] TX_ONE      = (TX_AW+1)'(1);
    localparam logic [RX_AW:0] RX_ONE      = (RX_AW+1)'(1);
    localparam logic [TX_AW:0] TX_FULL_LVL = (TX_AW+1)'(2**TX_AW - FULL_MARGIN);

    state_t state_reg, state_next;

    logic [7:0]     tx_mem [0:2**TX_AW-1];
    logic [7:0]     rx_mem [0:2**RX_AW-1];
    logic [TX_AW:0] tx_wptr_reg, tx_rptr_reg, tx_wptr_next, tx_rptr_next, tx_count_next;
    logic [RX_AW:0] rx_wptr_reg, rx_rptr_reg, rx_wptr_next, rx_rptr_next;
    logic           rx_ovf_reg;
    logic [31:0]    cnt_reg;
    logic [23:0]    snap_reg;

    logic       acc, rd, wr;
    logic [2:0] sel;
    logic       tx_empty, tx_full_raw, tx_push, tx_pop;
    logic       rx_empty, rx_full, rx_push, rx_pop;
    logic       unused_addr_bits;

    assign acc = rdy_in & (mem_a[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] == 2'b11);
    assign sel = mem_a[2:0];
    assign rd  = acc & ~mem_wr;
    assign wr  = acc & mem_wr;
    assign unused_addr_bits = ^{mem_a[31:RAM_ADDR_WIDTH+1], mem_a[RAM_ADDR_WIDTH-2:3]};

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign tx_empty    = (tx_wptr_reg == tx_rptr_reg);
    assign tx_full_raw = (tx_wptr_reg[TX_AW] != tx_rptr_reg[TX_AW]) &&
                         (tx_wptr_reg[TX_AW-1:0] == tx_rptr_reg[TX_AW-1:0]);
    assign rx_empty    = (rx_wptr_reg == rx_rptr_reg);
    assign rx_full     = (rx_wptr_reg[RX_AW] != rx_rptr_reg[RX_AW]) &&
                         (rx_wptr_reg[RX_AW-1:0] == rx_rptr_reg[RX_AW-1:0]);

    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rptr_reg[TX_AW-1:0]];

    assign tx_push = wr & (sel == 3'd0) & ~tx_full_raw & (state_reg == RUN);
    assign tx_pop  = tx_valid & tx_ready;
    assign rx_push = rx_valid & ~rx_full;
    assign rx_pop  = rd & (sel == 3'd0) & ~rx_empty;

    always_comb begin
        tx_wptr_next  = tx_push ? tx_wptr_reg + TX_ONE : tx_wptr_reg;
        tx_rptr_next  = tx_pop  ? tx_rptr_reg + TX_ONE : tx_rptr_reg;
        rx_wptr_next  = rx_push ? rx_wptr_reg + RX_ONE : rx_wptr_reg;
        rx_rptr_next  = rx_pop  ? rx_rptr_reg + RX_ONE : rx_rptr_reg;
        tx_count_next = tx_wptr_next - tx_rptr_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (wr && sel == 3'd4) state_next = DRAIN;
            DRAIN:   if (tx_empty) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (tx_push) tx_mem[tx_wptr_reg[TX_AW-1:0]] <= mem_dout;
        if (rx_push) rx_mem[rx_wptr_reg[RX_AW-1:0]] <= rx_data;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= RUN;
            program_finish <= 1'b0;
            io_buffer_full <= 1'b0;
            tx_wptr_reg    <= '0;
            tx_rptr_reg    <= '0;
            rx_wptr_reg    <= '0;
            rx_rptr_reg    <= '0;
            rx_ovf_reg     <= 1'b0;
            cnt_reg        <= '0;
            snap_reg       <= '0;
            io_din         <= 8'h00;
            exit_code      <= 8'h00;
        end else begin
            state_reg      <= state_next;
            program_finish <= (state_next == DONE);
            io_buffer_full <= (tx_count_next >= TX_FULL_LVL) | (state_next != RUN);
            tx_wptr_reg    <= tx_wptr_next;
            tx_rptr_reg    <= tx_rptr_next;
            rx_wptr_reg    <= rx_wptr_next;
            rx_rptr_reg    <= rx_rptr_next;
            cnt_reg        <= cnt_reg + 32'd1;

            // A new overflow in the same cycle as a clear wins, so no drop goes unreported.
            if (rx_valid && rx_full)
                rx_ovf_reg <= 1'b1;
            else if (wr && sel == 3'd1 && mem_dout[2])
                rx_ovf_reg <= 1'b0;

            if (wr && sel == 3'd4)
                exit_code <= mem_dout;

            if (rd) begin
                case (sel)
                    3'd0: io_din <= rx_empty ? 8'h00 : rx_mem[rx_rptr_reg[RX_AW-1:0]];
                    3'd1: io_din <= {5'b0, rx_ovf_reg, ~rx_empty, tx_full_raw};
                    3'd4: begin
                        io_din   <= cnt_reg[7:0];
                        snap_reg <= cnt_reg[31:8];
                    end
                    3'd5: io_din <= snap_reg[7:0];
                    3'd6: io_din <= snap_reg[15:8];
                    3'd7: io_din <= snap_reg[23:16];
                    default: io_din <= 8'h00;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder: TX/RX FIFOs, status, counter snapshot, finish and reset.
`timescale 1ns/1ps
module tb_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  io_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        program_finish;
    logic [7:0]  exit_code;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [7:0]  txq[$];
    logic [31:0] model_cnt;

    io_responder dut (
        .clk_in(clk_in), .rst_n(rst_n), .rdy_in(rdy_in), .mem_a(mem_a), .mem_wr(mem_wr),
        .mem_dout(mem_dout), .io_din(io_din), .io_buffer_full(io_buffer_full),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .program_finish(program_finish), .exit_code(exit_code)
    );

    always #5 clk_in = ~clk_in;

    // Inputs change 1ns after posedge, so at negedge they equal what the next posedge sees.
    always @(negedge clk_in)
        if (rst_n && tx_valid && tx_ready) txq.push_back(tx_data);

    always @(posedge clk_in or negedge rst_n)
        if (!rst_n) model_cnt <= 32'd0;
        else        model_cnt <= model_cnt + 32'd1;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [7:0] data);
        rdy_in = 1'b1; mem_wr = 1'b1; mem_a = addr; mem_dout = data;
        step();
        rdy_in = 1'b0; mem_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [7:0] data);
        rdy_in = 1'b1; mem_wr = 1'b0; mem_a = addr;
        step();
        rdy_in = 1'b0;
        data = io_din;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        steps(2);
        rst_n = 1'b1;
        txq.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rdy_in = 1'b0; mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00;
        tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        steps(2);
        vec_cnt++;
        if (io_din !== 8'h00 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset_data io_din=%h tx_valid=%b tx_data=%h, want 00/0/00", io_din, tx_valid, tx_data);
        end
        vec_cnt++;
        if (io_buffer_full !== 1'b0 || program_finish !== 1'b0 || exit_code !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset_ctrl full=%b finish=%b exit=%h, want 0/0/00", io_buffer_full, program_finish, exit_code);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_tx_basic();
        tx_ready = 1'b1;
        bus_write(32'h0003_0000, 8'h41);
        bus_write(32'h0003_0000, 8'h42);
        steps(4);
        vec_cnt++;
        if (txq.size() != 2 || txq[0] !== 8'h41 || txq[1] !== 8'h42) begin
            err_cnt++;
            $display("FAIL tx_basic got %0d bytes first=%h, want 2 bytes 41 42", txq.size(), (txq.size() > 0) ? txq[0] : 8'hxx);
        end
        vec_cnt++;
        if (tx_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL tx_idle tx_valid=%b, want 0", tx_valid);
        end
        txq.delete();
    endtask

    task automatic test_tx_full();
        logic [7:0] rd;
        tx_ready = 1'b0;
        for (int i = 0; i < 13; i++) bus_write(32'h0003_0000, 8'(i + 1));
        vec_cnt++;
        if (io_buffer_full !== 1'b0) begin
            err_cnt++;
            $display("FAIL full_13 io_buffer_full=%b, want 0", io_buffer_full);
        end
        bus_write(32'h0003_0000, 8'd14);
        vec_cnt++;
        if (io_buffer_full !== 1'b1) begin
            err_cnt++;
            $display("FAIL full_14 io_buffer_full=%b, want 1", io_buffer_full);
        end
        for (int i = 14; i < 17; i++) bus_write(32'h0003_0000, 8'(i + 1));
        bus_read(32'h0003_0001, rd);
        vec_cnt++;
        if (rd !== 8'h01) begin
            err_cnt++;
            $display("FAIL status_txfull got=%h want=01", rd);
        end
        tx_ready = 1'b1;
        steps(20);
        vec_cnt++;
        if (txq.size() != 16) begin
            err_cnt++;
            $display("FAIL tx_drain_count got=%0d want=16", txq.size());
        end
        for (int i = 0; i < 16 && i < txq.size(); i++) begin
            vec_cnt++;
            if (txq[i] !== 8'(i + 1)) begin
                err_cnt++;
                $display("FAIL tx_order[%0d] got=%h want=%h", i, txq[i], 8'(i + 1));
            end
        end
        vec_cnt++;
        if (io_buffer_full !== 1'b0) begin
            err_cnt++;
            $display("FAIL full_clear io_buffer_full=%b, want 0", io_buffer_full);
        end
        txq.delete();
    endtask

    task automatic test_rx();
        logic [7:0] rd;
        for (int i = 0; i < 17; i++) begin
            rx_valid = 1'b1; rx_data = 8'(i + 1);
            step();
            rx_valid = 1'b0;
        end
        bus_read(32'h0003_0001, rd);
        vec_cnt++;
        if (rd !== 8'h06) begin
            err_cnt++;
            $display("FAIL rx_status_ovf got=%h want=06", rd);
        end
        for (int i = 0; i < 17; i++) begin
            bus_read(32'h0003_0000, rd);
            vec_cnt++;
            if (rd !== ((i < 16) ? 8'(i + 1) : 8'h00)) begin
                err_cnt++;
                $display("FAIL rx_read[%0d] got=%h want=%h", i, rd, (i < 16) ? 8'(i + 1) : 8'h00);
            end
        end
        bus_read(32'h0003_0001, rd);
        vec_cnt++;
        if (rd !== 8'h04) begin
            err_cnt++;
            $display("FAIL rx_status_empty got=%h want=04", rd);
        end
        bus_write(32'h0003_0001, 8'h04);
        bus_read(32'h0003_0001, rd);
        vec_cnt++;
        if (rd !== 8'h00) begin
            err_cnt++;
            $display("FAIL rx_ovf_clear got=%h want=00", rd);
        end
    endtask

    task automatic test_counter();
        logic [31:0] exp;
        logic [7:0]  b0, b1, b2, b3;
        exp = model_cnt;
        bus_read(32'h0003_0004, b0);
        steps(300);
        bus_read(32'h0003_0005, b1);
        bus_read(32'h0003_0006, b2);
        bus_read(32'h0003_0007, b3);
        vec_cnt++;
        if ({b3, b2, b1, b0} !== exp) begin
            err_cnt++;
            $display("FAIL cnt_snapshot got=%h want=%h", {b3, b2, b1, b0}, exp);
        end
    endtask

    task automatic test_finish();
        logic [7:0] rd;
        tx_ready = 1'b0;
        bus_write(32'h0003_0000, 8'hA1);
        bus_write(32'h0003_0000, 8'hA2);
        bus_write(32'h0003_0000, 8'hA3);
        tx_ready = 1'b1;
        bus_write(32'h0003_0004, 8'h2A);
        vec_cnt++;
        if (io_buffer_full !== 1'b1 || program_finish !== 1'b0) begin
            err_cnt++;
            $display("FAIL drain_flags full=%b finish=%b, want 1/0", io_buffer_full, program_finish);
        end
        steps(8);
        vec_cnt++;
        if (txq.size() != 3 || txq[0] !== 8'hA1 || txq[2] !== 8'hA3) begin
            err_cnt++;
            $display("FAIL drain_bytes count=%0d, want 3 bytes A1 A2 A3", txq.size());
        end
        vec_cnt++;
        if (program_finish !== 1'b1 || exit_code !== 8'h2A) begin
            err_cnt++;
            $display("FAIL done finish=%b exit=%h, want 1/2a", program_finish, exit_code);
        end
        bus_write(32'h0003_0000, 8'h55);
        steps(3);
        vec_cnt++;
        if (txq.size() != 3 || tx_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL done_drop count=%0d tx_valid=%b, want 3/0", txq.size(), tx_valid);
        end
        bus_read(32'h0003_0001, rd);
        vec_cnt++;
        if (rd !== 8'h00 || io_buffer_full !== 1'b1) begin
            err_cnt++;
            $display("FAIL done_read status=%h full=%b, want 00/1", rd, io_buffer_full);
        end
        txq.delete();
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd;
        do_reset();
        tx_ready = 1'b0;
        bus_write(32'h0003_0000, 8'h11);
        bus_write(32'h0003_0000, 8'h22);
        bus_write(32'h0003_0004, 8'h07);
        vec_cnt++;
        if (tx_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL mid_pre tx_valid=%b want=1", tx_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0) begin
            err_cnt++;
            $display("FAIL mid_async tx_valid=%b full=%b, want 0/0", tx_valid, io_buffer_full);
        end
        step();
        rst_n = 1'b1;
        txq.delete();
        bus_read(32'h0003_0004, rd);
        vec_cnt++;
        if (rd !== 8'h00) begin
            err_cnt++;
            $display("FAIL mid_cnt got=%h want=00", rd);
        end
        bus_read(32'h0003_0001, rd);
        vec_cnt++;
        if (rd !== 8'h00 || program_finish !== 1'b0 || exit_code !== 8'h00) begin
            err_cnt++;
            $display("FAIL mid_state status=%h finish=%b exit=%h, want 00/0/00", rd, program_finish, exit_code);
        end
        tx_ready = 1'b1;
        bus_write(32'h0003_0000, 8'h77);
        steps(3);
        vec_cnt++;
        if (txq.size() != 1 || txq[0] !== 8'h77) begin
            err_cnt++;
            $display("FAIL mid_run count=%0d, want 1 byte 77", txq.size());
        end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_full();
        test_rx();
        test_counter();
        test_finish();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
